// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game sequencer.
// Picks a box from the LFSR, raises the mole, judges hits and keeps score.
module mole_scheduler #(
    parameter int GAP_CYCLES = 25_000_000,
    parameter int UP_CYCLES  = 50_000_000,
    parameter int UP_STEP    = 2_500_000,
    parameter int UP_MIN     = 12_500_000,
    parameter int ROUNDS     = 16,
    parameter int CNT_W      = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] lfsr_in,
    input  logic       hit_valid,
    input  logic [1:0] hit_box,
    output logic       mole_valid,
    output logic [1:0] mole_box,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [7:0] round,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHOW,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] L_GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_UP       = CNT_W'(UP_CYCLES);
    localparam logic [CNT_W-1:0] L_STEP     = CNT_W'(UP_STEP);
    localparam logic [CNT_W-1:0] L_MIN      = CNT_W'(UP_MIN);
    localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);
    localparam logic [CNT_W:0]   L_FLOOR    = (CNT_W+1)'(UP_MIN + UP_STEP);
    localparam logic [7:0]       L_ROUNDS   = 8'(ROUNDS);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_window;
    logic [1:0]       r_box;
    logic [7:0]       r_score;
    logic [7:0]       r_misses;
    logic [7:0]       r_round;
    logic             r_mole_valid;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_window_nxt;
    logic [1:0]       w_box_nxt;
    logic [7:0]       w_score_nxt;
    logic [7:0]       w_misses_nxt;
    logic [7:0]       w_round_nxt;
    logic [1:0]       w_map;
    logic [CNT_W-1:0] w_win_dec;
    logic             w_hit;
    logic             w_tmo;

    // Shrunk window never goes below the floor and never wraps.
    assign w_win_dec = ({1'b0, r_window} >= L_FLOOR) ? (r_window - L_STEP) : L_MIN;
    assign w_hit     = hit_valid && (hit_box == r_box);
    assign w_tmo     = (r_cnt == (r_window - L_ONE));

    // Non-uniform LFSR-to-box map; 000 falls back to box 0.
    always_comb begin
        w_map = 2'd0;
        case (lfsr_in)
            3'b011, 3'b101: w_map = 2'd1;
            3'b110:         w_map = 2'd2;
            3'b111:         w_map = 2'd3;
            default:        w_map = 2'd0;
        endcase
    end

    // Next-state and next-value logic for the game sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_window_nxt = r_window;
        w_box_nxt    = r_box;
        w_score_nxt  = r_score;
        w_misses_nxt = r_misses;
        w_round_nxt  = r_round;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_score_nxt  = 8'd0;
                    w_misses_nxt = 8'd0;
                    w_round_nxt  = 8'd0;
                    w_window_nxt = L_UP;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == L_GAP_LAST) begin
                    w_box_nxt   = w_map;
                    w_round_nxt = r_round + 8'd1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHOW;
                end else begin
                    w_cnt_nxt = r_cnt + L_ONE;
                end
            end
            S_SHOW: begin
                w_cnt_nxt = r_cnt + L_ONE;
                if (w_hit) begin
                    w_score_nxt  = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                    w_window_nxt = w_win_dec;
                end else if (w_tmo) begin
                    w_misses_nxt = (r_misses == 8'hFF) ? r_misses : r_misses + 8'd1;
                end
                if (w_hit || w_tmo) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_round == L_ROUNDS) ? S_DONE : S_WAIT;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_window     <= L_UP;
            r_box        <= 2'd0;
            r_score      <= 8'd0;
            r_misses     <= 8'd0;
            r_round      <= 8'd0;
            r_mole_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_window     <= w_window_nxt;
            r_box        <= w_box_nxt;
            r_score      <= w_score_nxt;
            r_misses     <= w_misses_nxt;
            r_round      <= w_round_nxt;
            r_mole_valid <= (w_state_nxt == S_SHOW);
            r_busy       <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_SHOW);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    assign mole_valid = r_mole_valid;
    assign mole_box   = r_box;
    assign score      = r_score;
    assign misses     = r_misses;
    assign round      = r_round;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed bench for the whack-a-mole sequencer.
// Two instances share inputs: a 3-round game and a 5-round game.
module tb_mole_scheduler;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] lfsr_in;
    logic       hit_valid;
    logic [1:0] hit_box;

    logic       mv3, by3, dn3, mv5, by5, dn5;
    logic [1:0] mb3, mb5;
    logic [7:0] sc3, mi3, rd3, sc5, mi5, rd5;

    logic       sel;
    logic       w_mv, w_busy, w_done;
    logic [1:0] w_box;
    logic [7:0] w_sc, w_mi, w_rd;

    int n_tests = 0;
    int n_fail  = 0;
    int gap, up;
    logic [1:0] exp_map [8];

    mole_scheduler #(
        .GAP_CYCLES(4), .UP_CYCLES(8), .UP_STEP(2),
        .UP_MIN(4), .ROUNDS(3), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .lfsr_in(lfsr_in),
        .hit_valid(hit_valid), .hit_box(hit_box),
        .mole_valid(mv3), .mole_box(mb3), .score(sc3), .misses(mi3),
        .round(rd3), .busy(by3), .done(dn3)
    );

    mole_scheduler #(
        .GAP_CYCLES(4), .UP_CYCLES(8), .UP_STEP(2),
        .UP_MIN(4), .ROUNDS(5), .CNT_W(4)
    ) dut5 (
        .clk(clk), .reset(reset), .start(start), .lfsr_in(lfsr_in),
        .hit_valid(hit_valid), .hit_box(hit_box),
        .mole_valid(mv5), .mole_box(mb5), .score(sc5), .misses(mi5),
        .round(rd5), .busy(by5), .done(dn5)
    );

    assign w_mv   = sel ? mv5 : mv3;
    assign w_box  = sel ? mb5 : mb3;
    assign w_sc   = sel ? sc5 : sc3;
    assign w_mi   = sel ? mi5 : mi3;
    assign w_rd   = sel ? rd5 : rd3;
    assign w_busy = sel ? by5 : by3;
    assign w_done = sel ? dn5 : dn3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Cycles until the selected mole rises, bounded.
    task automatic wait_up(output int g);
        g = 0;
        while (!w_mv && g < 50) begin
            step();
            g++;
        end
    endtask

    // Cycles the mole stays up; optional strike on cycle hit_at.
    task automatic watch_up(input int hit_at, input logic [1:0] hb, output int u);
        u = 0;
        while (w_mv && u < 50) begin
            u++;
            if (u == hit_at) begin
                hit_valid = 1'b1;
                hit_box   = hb;
            end
            step();
            hit_valid = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mv"},    32'(w_mv),   0);
        chk({tag, "_box"},   32'(w_box),  0);
        chk({tag, "_score"}, 32'(w_sc),   0);
        chk({tag, "_miss"},  32'(w_mi),   0);
        chk({tag, "_round"}, 32'(w_rd),   0);
        chk({tag, "_busy"},  32'(w_busy), 0);
        chk({tag, "_done"},  32'(w_done), 0);
    endtask

    initial begin
        exp_map   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
        sel       = 1'b0;
        reset     = 1'b1;
        start     = 1'b0;
        lfsr_in   = 3'b000;
        hit_valid = 1'b0;
        hit_box   = 2'd0;
        do_reset();

        // Reset state, then idle with a stray hit.
        chk_zero("rst");
        for (int i = 0; i < 20; i++) begin
            hit_valid = (i == 5);
            step();
        end
        hit_valid = 1'b0;
        chk_zero("idle");

        // Three unhit moles in box 2.
        lfsr_in = 3'b110;
        pulse_start();
        chk("start_busy", 32'(w_busy), 1);
        chk("start_mv", 32'(w_mv), 0);
        for (int r = 1; r <= 3; r++) begin
            wait_up(gap);
            chk("miss_gap", gap, 4);
            chk("miss_box", 32'(w_box), 2);
            chk("miss_round", 32'(w_rd), r);
            watch_up(0, 2'd0, up);
            chk("miss_up", up, 8);
            chk("miss_cnt", 32'(w_mi), r);
        end
        chk("miss_done", 32'(w_done), 1);
        chk("miss_busy", 32'(w_busy), 0);
        chk("miss_score", 32'(w_sc), 0);
        chk("miss_round3", 32'(w_rd), 3);
        step();
        step();
        chk("done_hold", 32'(w_done), 1);
        chk("done_hold_rd", 32'(w_rd), 3);

        // Start from DONE clears and replays; hit every mole on cycle 2.
        pulse_start();
        chk("restart_done", 32'(w_done), 0);
        chk("restart_miss", 32'(w_mi), 0);
        chk("restart_round", 32'(w_rd), 0);
        chk("restart_busy", 32'(w_busy), 1);
        for (int r = 1; r <= 3; r++) begin
            wait_up(gap);
            chk("hit_gap", gap, 4);
            watch_up(2, 2'd2, up);
            chk("hit_up", up, 2);
            chk("hit_score", 32'(w_sc), r);
        end
        chk("hit_misses", 32'(w_mi), 0);
        chk("hit_done", 32'(w_done), 1);

        // Wrong box, then hit on the final window cycle, then window check.
        do_reset();
        lfsr_in = 3'b111;
        pulse_start();
        wait_up(gap);
        chk("edge_box", 32'(w_box), 3);
        watch_up(3, 2'd0, up);
        chk("wrong_up", up, 8);
        chk("wrong_score", 32'(w_sc), 0);
        chk("wrong_miss", 32'(w_mi), 1);
        wait_up(gap);
        watch_up(8, 2'd3, up);
        chk("last_up", up, 8);
        chk("last_score", 32'(w_sc), 1);
        chk("last_miss", 32'(w_mi), 1);
        wait_up(gap);
        watch_up(0, 2'd0, up);
        chk("shrunk_up", up, 6);
        chk("edge_done", 32'(w_done), 1);

        // start during SHOW is ignored; reset mid-SHOW clears everything.
        do_reset();
        lfsr_in = 3'b110;
        pulse_start();
        wait_up(gap);
        step();
        pulse_start();
        chk("ign_round", 32'(w_rd), 1);
        chk("ign_mv", 32'(w_mv), 1);
        watch_up(0, 2'd0, up);
        chk("ign_rest_up", up, 6);
        wait_up(gap);
        step();
        reset = 1'b1;
        step();
        chk_zero("midrst");
        reset = 1'b0;

        // Window floor on the 5-round instance.
        sel = 1'b1;
        do_reset();
        lfsr_in = 3'b111;
        pulse_start();
        for (int r = 1; r <= 4; r++) begin
            wait_up(gap);
            watch_up(2, 2'd3, up);
            chk("floor_hit_up", up, 2);
        end
        wait_up(gap);
        watch_up(0, 2'd0, up);
        chk("floor_up", up, 4);
        chk("floor_score", 32'(w_sc), 4);
        chk("floor_miss", 32'(w_mi), 1);
        chk("floor_round", 32'(w_rd), 5);
        chk("floor_done", 32'(w_done), 1);
        sel = 1'b0;

        // LFSR map sweep.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            lfsr_in = 3'(v);
            pulse_start();
            wait_up(gap);
            chk($sformatf("map_%0d", v), 32'(w_box), 32'(exp_map[v]));
        end
        lfsr_in = 3'b110;
        step();
        step();
        chk("box_stable", 32'(w_box), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
